sd_solver_param: RTL and testbench
==================================

// Module: sd_solver_param
// PURPOSE
//  Parametrised backtracking Sudoku solver. It is the next generation of the lab-03 solver.
//  It accepts a 9x9 board serially, in raster order (0 = blank), and solves up to MAX_BLANKS
//  blanks by depth-first search. It streams the solved blank values in raster order, or
//  emits a single error code.
//  New behaviour over the previous generation:
//   - configurable blank capacity
//   - clue legality check before search
//   - iteration watchdog
//   - zero-blank handling
//   - busy flag
// PARAMETERS
//  MAX_BLANKS  15     max blanks accepted per board (1..63)
//  MAX_ITER    65535  max FWD+BWD steps before abort (>=1)
//  ERR_CODE    10     4-bit value on out for any failure
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  in_valid   in   1  board digit strobe; exactly 81 consecutive cycles per board
//  in         in   4  digit 0..9 (0 = blank); values 10..15 are illegal
//  busy       out  1  high from the first in_valid until the cycle after the last output beat
//  out_valid  out  1  output beat strobe
//  out        out  4  solved digit, ERR_CODE, or 0 (board had no blanks)
// BEHAVIOUR
//  Reset and interface rules
//   - Reset (async, rst=1): out_valid=0, out=0, busy=0, state=IDLE.
//     Board, blank list, counters and watchdog are all cleared.
//   - Reset mid-load, mid-search or mid-output aborts the board with no further beats.
//   - out=0 whenever out_valid=0.
//   - Any in_valid while in SRCH/OUT is ignored (board not corrupted). The source must wait for busy=0.
//   - in_valid must not drop inside an 81-digit frame.
//  FSM: IDLE -> LOAD -> CHK -> SRCH -> OUT -> IDLE
//   - IDLE: first in_valid stores digit 0 and moves to LOAD.
//   - LOAD: stores digits 1..80 with a 7-bit counter (0..80).
//     A 0 digit appends {row,col} to the blank list; nblank saturates at MAX_BLANKS+1.
//     Any digit >9 sets the sticky flag bad_digit.
//     After digit 80: go to CHK.
//   - CHK (1 cycle): err = bad_digit | (nblank>MAX_BLANKS) | duplicate non-zero clue
//     in any row, column or 3x3 box.
//       err=1     -> OUT, one beat of ERR_CODE
//       nblank=0  -> OUT, one beat of 0
//       otherwise -> SRCH with ptr=0
//   - SRCH (1 step/cycle): cell = blank[ptr]; cand = smallest v in (board[cell],9] that is
//     absent from the cell's row, column and box.
//       cand found, ptr<nblank-1 -> write cand, ptr++
//       cand found, ptr=nblank-1 -> write cand; solved; go to OUT
//       no cand, ptr>0           -> write 0, ptr--
//       no cand, ptr=0           -> unsolvable; go to OUT with ERR_CODE
//     Each SRCH cycle increments the 16-bit iter counter.
//     iter reaching MAX_ITER before solve -> OUT with ERR_CODE (watchdog).
//     Solve and watchdog in the same cycle: solve wins.
//   - OUT: beats on consecutive cycles, registered.
//       solved -> nblank beats, board[blank[0]]..board[blank[nblank-1]] (raster order)
//       error or no blanks -> exactly one beat
//     After the last beat: IDLE, busy=0 next cycle. A new board may start the cycle busy=0.
//  Latency
//   - CHK is entered the cycle after digit 80.
//   - The first out_valid comes 2 cycles after the CHK cycle for error/zero-blank boards.
//   - For solvable boards, it comes 1 cycle after the solving SRCH step.
//  Arithmetic and width
//   - ptr/nblank width = clog2(MAX_BLANKS+2).
//   - Box index = 3*(row/3) + col/3.
//   - Board cells are 4 bits.
// TESTING
//  1. Valid puzzle with 15 blanks, unique solution
//     -> 15 consecutive beats matching the golden solution in raster order; busy drops after the last beat.
//  2. Solved board (no zeros)
//     -> exactly one beat with out=0; no SRCH cycles.
//  3. Row 0 = 5,5,0,...
//     -> duplicate detected in CHK; single beat out=10; 2-cycle latency from CHK.
//  4. Board with MAX_BLANKS+1 = 16 zeros
//     -> single beat out=10.
//  5. Legal clues but unsolvable (blank whose row/col/box hold 1..9)
//     -> backtrack to ptr=0; single beat out=10.
//  6. Hard puzzle with MAX_ITER=8
//     -> abort after 8 SRCH cycles; out=10.
//     Then rst pulse mid-OUT
//     -> out_valid=0 at once, busy=0; the next board solves normally.

Source files
------------

// File: rtl/sd_solver_param.sv
// Backtracking 9x9 Sudoku solver: serial board load, clue legality check, depth-first
// search with an iteration watchdog, and registered raster-order streaming of the solved blanks.
module sd_solver_param #(
  parameter int unsigned MAX_BLANKS = 15,
  parameter int unsigned MAX_ITER   = 65535,
  parameter logic [3:0]  ERR_CODE   = 4'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in,
  output logic       busy,
  output logic       out_valid,
  output logic [3:0] out
);

  localparam int unsigned PW    = $clog2(MAX_BLANKS + 2);
  localparam int unsigned BD    = 1 << PW;
  localparam int unsigned CELLS = 81;

  typedef enum logic [2:0] {IDLE, LOAD, CHK, SRCH, OUT} state_t;

  state_t          state, state_n;
  logic [6:0]      cnt, cnt_n;
  logic [PW-1:0]   nblank, nblank_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic [PW-1:0]   oidx, oidx_n;
  logic [15:0]     iter, iter_n;
  logic            bad_digit, bad_n;
  logic            err, err_n;
  logic            busy_n, out_valid_n;
  logic [3:0]      out_n;

  logic [3:0]      board [CELLS];
  logic [7:0]      blank [BD];

  logic            bwr_en;
  logic [6:0]      bwr_addr;
  logic [3:0]      bwr_data;
  logic            lwr_en;
  logic [PW-1:0]   lwr_addr;
  logic [7:0]      lwr_data;

  logic            dup;
  logic [8:0]      rm, cm, bm;
  logic [3:0]      rv, cv, bv;

  logic [7:0]      cur_rc;
  logic [6:0]      cur_cell;
  logic [3:0]      cur_val;
  logic [3:0]      br, bc;
  logic [8:0]      used;
  logic            found;
  logic [3:0]      cand;

  logic [PW-1:0]   last;
  logic [15:0]     iter_inc;
  logic            wdog;
  logic [3:0]      ld_row, ld_col;

  // Digits 1..9 map to bits 0..8; blanks and illegal digits contribute nothing.
  function automatic logic [8:0] digit_mask(input logic [3:0] d);
    if (d >= 4'd1 && d <= 4'd9) return 9'd1 << (d - 4'd1);
    return 9'd0;
  endfunction

  function automatic logic [6:0] cell_of(input logic [7:0] rc);
    return 7'(rc[7:4]) * 7'd9 + 7'(rc[3:0]);
  endfunction

  assign last     = nblank - PW'(1);
  assign iter_inc = iter + 16'd1;
  assign wdog     = (iter_inc >= 16'(MAX_ITER));
  assign ld_row   = 4'(cnt / 7'd9);
  assign ld_col   = 4'(cnt % 7'd9);

  // Duplicate non-zero clue in any row, column or box.
  always_comb begin
    dup = 1'b0;
    rm  = '0;
    cm  = '0;
    bm  = '0;
    rv  = '0;
    cv  = '0;
    bv  = '0;
    for (int u = 0; u < 9; u++) begin
      rm = '0;
      cm = '0;
      bm = '0;
      for (int i = 0; i < 9; i++) begin
        rv = board[7'(u * 9 + i)];
        cv = board[7'(i * 9 + u)];
        bv = board[7'(((u / 3) * 3 + i / 3) * 9 + (u % 3) * 3 + i % 3)];
        if ((rm & digit_mask(rv)) != 9'd0) dup = 1'b1;
        if ((cm & digit_mask(cv)) != 9'd0) dup = 1'b1;
        if ((bm & digit_mask(bv)) != 9'd0) dup = 1'b1;
        rm = rm | digit_mask(rv);
        cm = cm | digit_mask(cv);
        bm = bm | digit_mask(bv);
      end
    end
  end

  // Next candidate for the blank under the search pointer.
  always_comb begin
    cur_rc   = blank[ptr];
    cur_cell = cell_of(cur_rc);
    cur_val  = board[cur_cell];
    br       = 4'(cur_rc[7:4] / 4'd3 * 4'd3);
    bc       = 4'(cur_rc[3:0] / 4'd3 * 4'd3);
    used     = '0;
    for (int i = 0; i < 9; i++) begin
      used = used | digit_mask(board[7'(int'(cur_rc[7:4]) * 9 + i)]);
      used = used | digit_mask(board[7'(i * 9 + int'(cur_rc[3:0]))]);
      used = used | digit_mask(board[7'((int'(br) + i / 3) * 9 + int'(bc) + i % 3)]);
    end
    found = 1'b0;
    cand  = '0;
    for (int v = 9; v >= 1; v--) begin
      if (4'(v) > cur_val && !used[4'(v - 1)]) begin
        found = 1'b1;
        cand  = 4'(v);
      end
    end
  end

  // Next-state, datapath control and registered-output values.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    nblank_n    = nblank;
    ptr_n       = ptr;
    oidx_n      = oidx;
    iter_n      = iter;
    bad_n       = bad_digit;
    err_n       = err;
    busy_n      = 1'b1;
    out_valid_n = 1'b0;
    out_n       = '0;
    bwr_en      = 1'b0;
    bwr_addr    = '0;
    bwr_data    = '0;
    lwr_en      = 1'b0;
    lwr_addr    = '0;
    lwr_data    = '0;
    case (state)
      IDLE: begin
        busy_n = in_valid;
        if (in_valid) begin
          state_n  = LOAD;
          cnt_n    = 7'd1;
          bad_n    = (in > 4'd9);
          err_n    = 1'b0;
          ptr_n    = '0;
          oidx_n   = '0;
          iter_n   = '0;
          bwr_en   = 1'b1;
          bwr_data = in;
          nblank_n = (in == 4'd0) ? PW'(1) : '0;
          lwr_en   = (in == 4'd0);
        end
      end
      LOAD: begin
        if (in_valid) begin
          bwr_en   = 1'b1;
          bwr_addr = cnt;
          bwr_data = in;
          if (in > 4'd9) bad_n = 1'b1;
          if (in == 4'd0) begin
            if (nblank < PW'(MAX_BLANKS)) begin
              lwr_en   = 1'b1;
              lwr_addr = nblank;
              lwr_data = {ld_row, ld_col};
            end
            if (nblank <= PW'(MAX_BLANKS)) nblank_n = nblank + PW'(1);
          end
          cnt_n = cnt + 7'd1;
          if (cnt == 7'd80) state_n = CHK;
        end
      end
      CHK: begin
        if (bad_digit || nblank > PW'(MAX_BLANKS) || dup) begin
          err_n   = 1'b1;
          state_n = OUT;
        end else if (nblank == '0) begin
          state_n = OUT;
        end else begin
          state_n = SRCH;
          ptr_n   = '0;
          iter_n  = '0;
        end
      end
      SRCH: begin
        iter_n   = iter_inc;
        bwr_en   = 1'b1;
        bwr_addr = cur_cell;
        bwr_data = found ? cand : 4'd0;
        if (found && ptr == last) begin
          // Solved: the first beat leaves with this step.
          out_valid_n = 1'b1;
          out_n       = (ptr == '0) ? cand : board[cell_of(blank[0])];
          oidx_n      = PW'(1);
          state_n     = (nblank == PW'(1)) ? IDLE : OUT;
        end else if (!found && ptr == '0) begin
          err_n   = 1'b1;
          state_n = OUT;
        end else begin
          ptr_n = found ? ptr + PW'(1) : ptr - PW'(1);
          if (wdog) begin
            err_n   = 1'b1;
            state_n = OUT;
          end
        end
      end
      OUT: begin
        out_valid_n = 1'b1;
        if (err) begin
          out_n   = ERR_CODE;
          state_n = IDLE;
        end else if (nblank == '0) begin
          out_n   = 4'd0;
          state_n = IDLE;
        end else begin
          out_n  = board[cell_of(blank[oidx])];
          oidx_n = oidx + PW'(1);
          if (oidx == last) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      nblank    <= '0;
      ptr       <= '0;
      oidx      <= '0;
      iter      <= '0;
      bad_digit <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      nblank    <= nblank_n;
      ptr       <= ptr_n;
      oidx      <= oidx_n;
      iter      <= iter_n;
      bad_digit <= bad_n;
      err       <= err_n;
      busy      <= busy_n;
      out_valid <= out_valid_n;
      out       <= out_n;
    end
  end

  // Board cells and blank list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(CELLS); i++) board[i] <= '0;
      for (int i = 0; i < int'(BD); i++) blank[i] <= '0;
    end else begin
      if (bwr_en) board[bwr_addr] <= bwr_data;
      if (lwr_en) blank[lwr_addr] <= lwr_data;
    end
  end

endmodule

// File: tb/tb_sd_solver_param.sv
// Directed bench for sd_solver_param: default instance plus a MAX_ITER=8 instance for the watchdog.
module tb_sd_solver_param;

  logic       clk = 1'b0;
  logic       rst1, rst2;
  logic       iv1, iv2;
  logic [3:0] d1, d2;
  logic       busy1, busy2, ov1, ov2;
  logic [3:0] o1, o2;

  int n_cmp = 0;
  int n_err = 0;

  int gold [81] = '{5,3,4,6,7,8,9,1,2,
                    6,7,2,1,9,5,3,4,8,
                    1,9,8,3,4,2,5,6,7,
                    8,5,9,7,6,1,4,2,3,
                    4,2,6,8,5,3,7,9,1,
                    7,1,3,9,2,4,8,5,6,
                    9,6,1,5,3,7,2,8,4,
                    2,8,7,4,1,9,6,3,5,
                    3,4,5,2,8,6,1,7,9};
  int brd [81];
  int exp_q [$];

  always #5 clk = ~clk;

  sd_solver_param dut1 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in(d1),
    .busy(busy1), .out_valid(ov1), .out(o1)
  );

  sd_solver_param #(.MAX_ITER(8)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(iv2), .in(d2),
    .busy(busy2), .out_valid(ov2), .out(o2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ov_of(input int s);
    return (s != 0) ? int'(ov2) : int'(ov1);
  endfunction
  function automatic int out_of(input int s);
    return (s != 0) ? int'(o2) : int'(o1);
  endfunction
  function automatic int busy_of(input int s);
    return (s != 0) ? int'(busy2) : int'(busy1);
  endfunction

  task automatic drive(input int s, input logic v, input int d);
    if (s != 0) begin iv2 = v; d2 = 4'(d); end
    else begin iv1 = v; d1 = 4'(d); end
  endtask

  task automatic load_gold();
    for (int i = 0; i < 81; i++) brd[i] = gold[i];
  endtask

  // Expected beats of a solvable board: golden digits at blank cells, raster order.
  task automatic exp_solution();
    exp_q.delete();
    for (int i = 0; i < 81; i++) if (brd[i] == 0) exp_q.push_back(gold[i]);
  endtask

  task automatic exp_single(input int v);
    exp_q.delete();
    exp_q.push_back(v);
  endtask

  // Streams brd, measures edges from the last digit to the first beat, checks the beats.
  task automatic run_board(input int s, input string tag, input int exp_lat, input bit rst_mid);
    int k;
    int n;
    for (int i = 0; i < 81; i++) begin
      @(negedge clk);
      drive(s, 1'b1, brd[i]);
    end
    @(negedge clk);
    drive(s, 1'b0, 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ov_of(s) == 0 && k < 3000);
    chk({tag, "_latency"}, k, exp_lat);
    if (ov_of(s) == 0) return;
    chk({tag, "_busy_first"}, busy_of(s), 1);
    if (rst_mid) begin
      chk({tag, "_beat0"}, out_of(s), exp_q[0]);
      rst2 = 1'b1;
      #1;
      chk({tag, "_rst_ov"}, ov_of(s), 0);
      chk({tag, "_rst_busy"}, busy_of(s), 0);
      @(negedge clk);
      rst2 = 1'b0;
      return;
    end
    n = 0;
    while (ov_of(s) != 0 && n < 100) begin
      if (n < exp_q.size()) chk($sformatf("%s_beat%0d", tag, n), out_of(s), exp_q[n]);
      n++;
      @(negedge clk);
    end
    chk({tag, "_beats"}, n, exp_q.size());
    chk({tag, "_busy_after"}, busy_of(s), 0);
    chk({tag, "_out_idle"}, out_of(s), 0);
  endtask

  initial begin
    rst1 = 1'b1; rst2 = 1'b1;
    iv1 = 1'b0; iv2 = 1'b0; d1 = '0; d2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ov", int'(ov1), 0);
    chk("rst_out", int'(o1), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_busy2", int'(busy2), 0);
    rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);

    // 15 blanks, each chain-forced: no backtracking, so 1 CHK + 15 SRCH edges
    load_gold();
    for (int r = 0; r < 9; r++) brd[r * 10] = 0;
    for (int r = 0; r < 6; r++) brd[r * 10 + 1] = 0;
    exp_solution();
    run_board(0, "solve15", 16, 1'b0);

    load_gold();
    exp_single(0);
    run_board(0, "noblank", 2, 1'b0);

    load_gold();
    brd[1] = 5; brd[2] = 0;
    exp_single(10);
    run_board(0, "dup_row", 2, 1'b0);

    load_gold();
    for (int i = 0; i < 16; i++) brd[i] = 0;
    exp_single(10);
    run_board(0, "too_many", 2, 1'b0);

    // (0,0) sees 1..9 across its row and column; dead at ptr=0 on the first step
    load_gold();
    brd[0] = 0; brd[27] = 5; brd[28] = 0;
    exp_single(10);
    run_board(0, "unsolv", 3, 1'b0);

    // Watchdog: 8 SRCH steps then OUT, reset while the error beat is up
    load_gold();
    for (int r = 0; r < 9; r++) brd[r * 10] = 0;
    for (int r = 0; r < 6; r++) brd[r * 10 + 1] = 0;
    exp_single(10);
    run_board(1, "wdog", 10, 1'b1);

    load_gold();
    brd[0] = 0; brd[40] = 0; brd[80] = 0;
    exp_solution();
    run_board(1, "after_rst", 4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
